// File: rtl/lc3_mem_ctrl.sv
// lc3_mem_ctrl: single-outstanding LC-3 memory initiator with valid/ready request and response
// channels and a programmable number of wait states before the data phase.
module lc3_mem_ctrl #(
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 16,
    parameter int WAIT_CYCLES = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic [ADDR_W-1:0] MARReg,
    output logic [DATA_W-1:0] mdrOut,
    output logic              memWE,
    input  logic [DATA_W-1:0] memOut
);
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
    state_t      state, state_nx;
    logic [3:0]  cnt;
    logic        we_q;
    logic        last;
    always_comb begin
        last      = state == ACCESS && cnt == 4'd0;
        req_ready = reset && state == IDLE;
        rsp_valid = reset && state == RESP;
        // gated by reset so an abandoned store cannot reach the memory
        memWE     = reset && last && we_q;
        state_nx  = state == IDLE ? (req_valid ? ACCESS : IDLE) :
                    last ? RESP :
                    state == RESP ? (rsp_ready ? IDLE : RESP) :
                    state == ACCESS ? ACCESS : IDLE;
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            MARReg    <= '0;
            mdrOut    <= '0;
            rsp_rdata <= '0;
            cnt       <= 4'd0;
            we_q      <= 1'b0;
        end else begin
            state <= state_nx;
            if (state == IDLE && req_valid) begin
                MARReg <= req_addr;
                mdrOut <= req_wdata;
                we_q   <= req_we;
                cnt    <= 4'(WAIT_CYCLES);
            end else if (state == ACCESS) begin
                if (cnt != 4'd0)
                    cnt <= cnt - 4'd1;
                else
                    rsp_rdata <= we_q ? mdrOut : memOut;
            end
        end
    end
endmodule

// File: tb/tb_lc3_mem_ctrl.sv
// tb_lc3_mem_ctrl: three controllers (0, 3 and 2 wait states) each driving its own word memory,
// checked with a vector table, hand-written corner sequences and random transfers against a model.
module tb_lc3_mem_ctrl;
    logic        clk = 0;
    logic        reset = 0;
    logic        rv[3], rr[3], wei[3], rsv[3], rsr[3], mwe[3];
    logic [15:0] ra[3], wd[3], rd[3], mar[3], mdo[3], mo[3];
    logic [15:0] mem[3][65536];
    int          pcnt[3];
    int          tests = 0, fails = 0;
    logic [15:0] ref_mem[int];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : gen_dut
        lc3_mem_ctrl #(.WAIT_CYCLES(g == 0 ? 0 : (g == 1 ? 3 : 2))) dut (
            .clk(clk), .reset(reset),
            .req_valid(rv[g]), .req_ready(rr[g]), .req_we(wei[g]),
            .req_addr(ra[g]), .req_wdata(wd[g]),
            .rsp_valid(rsv[g]), .rsp_ready(rsr[g]), .rsp_rdata(rd[g]),
            .MARReg(mar[g]), .mdrOut(mdo[g]), .memWE(mwe[g]), .memOut(mo[g])
        );
        assign mo[g] = mem[g][mar[g]];
    end

    always @(posedge clk)
        for (int i = 0; i < 3; i++)
            if (mwe[i]) mem[i][mar[i]] <= mdo[i];

    always @(negedge clk)
        for (int i = 0; i < 3; i++)
            if (mwe[i]) pcnt[i] <= pcnt[i] + 1;

    function automatic int wait_of(input int g);
        return g == 0 ? 0 : (g == 1 ? 3 : 2);
    endfunction

    function automatic logic [15:0] ref_rd(input int g, input logic [15:0] a);
        int k = g * 65536 + int'(a);
        return ref_mem.exists(k) ? ref_mem[k] : 16'h0000;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic xfer(input int g, input bit we, input logic [15:0] addr, input logic [15:0] data,
                        input int hold, output logic [15:0] rdat, output int lat,
                        output int pulses, output bit stable);
        int w0, n;
        stable = 1;
        @(negedge clk);
        rv[g] = 1; wei[g] = we; ra[g] = addr; wd[g] = data; rsr[g] = 0;
        n = 0;
        while (!rr[g] && n < 50) begin @(negedge clk); n++; end
        if (!rr[g]) chk("accept_timeout", 32'(rr[g]), 1);
        w0 = pcnt[g];
        @(negedge clk);
        rv[g] = 0;
        lat = 1;
        if (mar[g] !== addr) stable = 0;
        while (!rsv[g] && lat < 50) begin
            @(negedge clk);
            lat++;
            if (mar[g] !== addr) stable = 0;
        end
        rdat = rd[g];
        repeat (hold) begin
            @(negedge clk);
            if (!rsv[g] || rd[g] !== rdat || rr[g] || mar[g] !== addr) stable = 0;
        end
        rsr[g] = 1;
        @(negedge clk);
        rsr[g] = 0;
        if (rsv[g] || !rr[g]) stable = 0;
        pulses = pcnt[g] - w0;
    endtask

    task automatic run(input string tag, input int g, input bit we, input logic [15:0] addr,
                       input logic [15:0] data, input logic [15:0] exp, input int hold);
        logic [15:0] r;
        int          lat, pulses;
        bit          st;
        xfer(g, we, addr, data, hold, r, lat, pulses, st);
        chk({tag, "_rdata"}, 32'(r), 32'(exp));
        chk({tag, "_latency"}, lat, wait_of(g) + 2);
        chk({tag, "_we_pulses"}, pulses, 32'(we));
        chk({tag, "_stable"}, 32'(st), 1);
        if (we) ref_mem[g * 65536 + int'(addr)] = data;
    endtask

    typedef struct {
        int          g;
        bit          we;
        logic [15:0] addr;
        logic [15:0] data;
        logic [15:0] exp;
        int          hold;
    } vec_t;

    initial begin
        vec_t        vt[8];
        bit          ok;
        logic [15:0] pool[6];
        for (int i = 0; i < 3; i++) begin
            rv[i] = 1; wei[i] = 0; ra[i] = 16'h1234; wd[i] = 16'h5555; rsr[i] = 0; pcnt[i] = 0;
            for (int a = 0; a < 65536; a++) mem[i][a] = 16'h0000;
        end
        vt[0] = '{0, 1, 16'h3000, 16'hBEEF, 16'hBEEF, 0};
        vt[1] = '{0, 0, 16'h3000, 16'h0000, 16'hBEEF, 0};
        vt[2] = '{0, 1, 16'hFFFF, 16'h1234, 16'h1234, 0};
        vt[3] = '{0, 0, 16'hFFFF, 16'h0000, 16'h1234, 2};
        vt[4] = '{1, 1, 16'h3000, 16'hA5A5, 16'hA5A5, 0};
        vt[5] = '{1, 0, 16'h3000, 16'h0000, 16'hA5A5, 4};
        vt[6] = '{2, 1, 16'h0000, 16'h0F0F, 16'h0F0F, 0};
        vt[7] = '{2, 0, 16'h0000, 16'h0000, 16'h0F0F, 1};

        // reset held with a request present
        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("rst_memWE%0d", i), 32'(mwe[i]), 0);
            chk($sformatf("rst_rsp_valid%0d", i), 32'(rsv[i]), 0);
            chk($sformatf("rst_req_ready%0d", i), 32'(rr[i]), 0);
            chk($sformatf("rst_MARReg%0d", i), 32'(mar[i]), 0);
            chk($sformatf("rst_rdata%0d", i), 32'(rd[i]), 0);
            rv[i] = 0;
        end
        reset = 1;
        @(posedge clk); #1;
        chk("req_ready_after_rst", 32'(rr[0]), 1);

        for (int i = 0; i < 8; i++)
            run($sformatf("vec%0d", i), vt[i].g, vt[i].we, vt[i].addr, vt[i].data, vt[i].exp, vt[i].hold);

        // backpressure with a pending request queued behind the response
        @(negedge clk);
        rv[0] = 1; wei[0] = 1; ra[0] = 16'h6000; wd[0] = 16'h1111; rsr[0] = 0;
        @(negedge clk);
        wei[0] = 0; ra[0] = 16'h3000;
        @(negedge clk);
        chk("bp_rsp_valid_rise", 32'(rsv[0]), 1);
        ok = 1;
        repeat (4) begin
            @(negedge clk);
            if (!rsv[0] || rd[0] !== 16'h1111 || rr[0] || mar[0] !== 16'h6000) ok = 0;
        end
        chk("bp_hold", 32'(ok), 1);
        rsr[0] = 1;
        @(negedge clk);
        rsr[0] = 0;
        chk("bp_idle_ready", 32'(rr[0]), 1);
        chk("bp_idle_rsp_valid", 32'(rsv[0]), 0);
        chk("bp_idle_mar", 32'(mar[0]), 32'h6000);
        @(negedge clk);
        rv[0] = 0;
        chk("bp_pending_accepted", 32'(mar[0]), 32'h3000);
        chk("bp_busy_ready", 32'(rr[0]), 0);
        ref_mem[16'h6000] = 16'h1111;
        begin
            int n = 0;
            while (!rsv[0] && n < 20) begin @(negedge clk); n++; end
        end
        chk("bp_pending_rdata", 32'(rd[0]), 32'(ref_rd(0, 16'h3000)));
        rsr[0] = 1;
        @(negedge clk);
        rsr[0] = 0;

        // reset in the final ACCESS cycle of a 2-wait store
        @(negedge clk);
        rv[2] = 1; wei[2] = 1; ra[2] = 16'h5000; wd[2] = 16'hDEAD;
        @(negedge clk);
        rv[2] = 0;
        repeat (2) @(negedge clk);
        chk("abort_we_before", 32'(mwe[2]), 1);
        reset = 0;
        #1;
        chk("abort_we_drop", 32'(mwe[2]), 0);
        chk("abort_rsp_valid", 32'(rsv[2]), 0);
        chk("abort_mar", 32'(mar[2]), 0);
        ok = 1;
        repeat (2) begin @(negedge clk); if (rsv[2] || mwe[2]) ok = 0; end
        reset = 1;
        repeat (3) begin @(negedge clk); if (rsv[2] || mwe[2]) ok = 0; end
        chk("abort_quiet", 32'(ok), 1);
        chk("abort_mem_unchanged", 32'(mem[2][16'h5000]), 32'(ref_rd(2, 16'h5000)));
        run("abort_load", 2, 0, 16'h5000, 16'h0000, ref_rd(2, 16'h5000), 0);

        // random traffic over a small address pool so loads often follow stores
        pool = '{16'h0000, 16'h0001, 16'h3000, 16'h3001, 16'hFFFE, 16'hFFFF};
        for (int k = 0; k < 90; k++) begin
            int          g  = int'($urandom_range(2));
            bit          we = 1'($urandom_range(1));
            logic [15:0] a  = pool[$urandom_range(5)];
            logic [15:0] d  = 16'($urandom);
            run($sformatf("rnd%0d", k), g, we, a, d, we ? d : ref_rd(g, a), int'($urandom_range(2)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
